// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave exposing eight 8-bit registers (0..6 writable, 7 = read-only ID).
// Latency: SPI pins see SYNC_STAGES+1 clk before acting; a write lands and pulses one clk after its 8th SCK rise.
// No backpressure: the SPI master paces every transfer, and SCK must stay at or below clk/8.
module spi_slave_regfile #(
   parameter logic [7:0] ID_VALUE    = 8'hA5,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        spi_cs_n,
   input  logic        spi_sck,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        spi_miso_oe,
   output logic [63:0] reg_out,
   output logic        wr_pulse,
   output logic [2:0]  wr_addr,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

   state_t r_state;
   state_t w_next_state;

   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic [SYNC_STAGES-1:0] r_warm;
   logic                   r_sck_q;
   logic                   r_armed;

   logic [2:0]  r_bit_cnt;
   logic [6:0]  r_rx_shift;
   logic [7:0]  r_tx_shift;
   logic [2:0]  r_addr;
   logic        r_rd_armed;
   logic        r_wr_pulse;
   logic [2:0]  r_wr_addr;
   logic [7:0]  r_regs [0:6];

   logic        w_cs_n;
   logic        w_sck;
   logic        w_mosi;
   logic        w_warm;
   logic        w_sck_rise;
   logic        w_sck_fall;
   logic        w_byte_done;
   logic [7:0]  w_rx_byte;
   logic [2:0]  w_addr_inc;
   logic [63:0] w_reg_flat;
   logic [7:0]  w_rd_cmd;
   logic [7:0]  w_rd_next;

   // Synchronizers reset to the bus idle level; r_warm marks when the chains hold real pin values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cs_sync   <= '1;
         r_sck_sync  <= '0;
         r_mosi_sync <= '0;
         r_warm      <= '0;
      end else begin
         r_cs_sync[0]   <= spi_cs_n;
         r_sck_sync[0]  <= spi_sck;
         r_mosi_sync[0] <= spi_mosi;
         r_warm[0]      <= 1'b1;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_cs_sync[i]   <= r_cs_sync[i-1];
            r_sck_sync[i]  <= r_sck_sync[i-1];
            r_mosi_sync[i] <= r_mosi_sync[i-1];
            r_warm[i]      <= r_warm[i-1];
         end
      end
   end

   assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
   assign w_sck  = r_sck_sync[SYNC_STAGES-1];
   assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
   assign w_warm = r_warm[SYNC_STAGES-1];

   // SCK edge history, and the arm flag: a transfer already running when reset lifts is
   // ignored until CS has been seen deasserted at least once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sck_q <= 1'b0;
         r_armed <= 1'b0;
      end else begin
         r_sck_q <= w_sck;
         r_armed <= r_armed | (w_warm & w_cs_n);
      end
   end

   assign w_sck_rise  = w_sck & ~r_sck_q;
   assign w_sck_fall  = ~w_sck & r_sck_q;
   assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7);
   assign w_rx_byte   = {r_rx_shift, w_mosi};
   assign w_addr_inc  = r_addr + 3'd1;

   // Flattened register view; slot 7 is the constant ID.
   always_comb begin
      w_reg_flat = '0;
      for (int i = 0; i < 7; i++) begin
         w_reg_flat[i*8 +: 8] = r_regs[i];
      end
      w_reg_flat[63:56] = ID_VALUE;
   end

   assign w_rd_cmd  = w_reg_flat[{w_rx_byte[2:0], 3'b000} +: 8];
   assign w_rd_next = w_reg_flat[{w_addr_inc, 3'b000} +: 8];
   assign reg_out   = w_reg_flat;
   assign wr_pulse  = r_wr_pulse;
   assign wr_addr   = r_wr_addr;

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and pin outputs; CS deassert returns to IDLE from any state.
   always_comb begin
      w_next_state = r_state;
      spi_miso     = 1'b0;
      busy         = 1'b0;
      spi_miso_oe  = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_armed && !w_cs_n) begin
               w_next_state = CMD;
            end
         end
         CMD: begin
            if (w_cs_n) begin
               w_next_state = IDLE;
            end else if (w_byte_done) begin
               w_next_state = w_rx_byte[7] ? READ : WRITE;
            end
         end
         WRITE: begin
            if (w_cs_n) begin
               w_next_state = IDLE;
            end
         end
         READ: begin
            if (w_cs_n) begin
               w_next_state = IDLE;
            end
            spi_miso = r_tx_shift[7];
         end
         default: w_next_state = IDLE;
      endcase
      busy        = (r_state != IDLE);
      spi_miso_oe = busy;
   end

   // Datapath: bit counting, command decode, register writes and read shifting.
   // A byte finishing on the same clk as CS deassert still completes because the
   // action keys on the current state, not the next one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bit_cnt  <= '0;
         r_rx_shift <= '0;
         r_tx_shift <= '0;
         r_addr     <= '0;
         r_rd_armed <= 1'b0;
         r_wr_pulse <= 1'b0;
         r_wr_addr  <= '0;
         for (int i = 0; i < 7; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         r_wr_pulse <= 1'b0;
         if (r_state == IDLE) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_rd_armed <= 1'b0;
         end else begin
            if (w_sck_rise) begin
               r_rx_shift <= w_rx_byte[6:0];
               r_bit_cnt  <= r_bit_cnt + 3'd1;
            end
            case (r_state)
               CMD: begin
                  if (w_byte_done) begin
                     r_addr <= w_rx_byte[2:0];
                     if (w_rx_byte[7]) begin
                        r_tx_shift <= w_rd_cmd;
                     end
                  end
               end
               WRITE: begin
                  if (w_byte_done) begin
                     for (int i = 0; i < 7; i++) begin
                        if (r_addr == i[2:0]) begin
                           r_regs[i] <= w_rx_byte;
                        end
                     end
                     r_wr_pulse <= 1'b1;
                     r_wr_addr  <= r_addr;
                     r_addr     <= w_addr_inc;
                  end
               end
               READ: begin
                  // The command byte's last falling edge arrives in READ with no
                  // rise before it; r_rd_armed keeps that edge from shifting.
                  if (w_sck_rise) begin
                     r_rd_armed <= 1'b1;
                  end else if (w_sck_fall && r_rd_armed) begin
                     r_rd_armed <= 1'b0;
                     if (r_bit_cnt == 3'd0) begin
                        r_addr     <= w_addr_inc;
                        r_tx_shift <= w_rd_next;
                     end else begin
                        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: SPI master tasks, write/read scoreboards and a stimulus table.
// SCK runs at clk/8, with inputs driven on the falling clock edge.
// Expected values come from table constants and a small register model.
module tb_spi_slave_regfile;

   localparam logic [7:0] ID = 8'hA5;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        spi_cs_n;
   logic        spi_sck;
   logic        spi_mosi;
   logic        spi_miso;
   logic        spi_miso_oe;
   logic [63:0] reg_out;
   logic        wr_pulse;
   logic [2:0]  wr_addr;
   logic        busy;

   spi_slave_regfile #(.ID_VALUE(ID), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .spi_cs_n    (spi_cs_n),
      .spi_sck     (spi_sck),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe),
      .reg_out     (reg_out),
      .wr_pulse    (wr_pulse),
      .wr_addr     (wr_addr),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] a;
      logic [7:0] d;
   } wexp_t;

   typedef struct {
      logic [7:0] cmd;
      logic [7:0] dat;
      logic [7:0] exp;
   } vec_t;

   wexp_t      wq[$];
   logic [7:0] rq[$];
   logic [7:0] bq[$];
   logic [7:0] model [0:7];
   wexp_t      mon_e;
   int         n_cmp = 0;
   int         n_err = 0;
   int         cs_hi_cnt = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Write-pulse scoreboard: each pulse pops one expected {addr, data}.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && wr_pulse === 1'b1) begin
         if (wq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_wr_pulse: wr_addr=%0d, expected no pulse", wr_addr);
         end else begin
            mon_e = wq.pop_front();
            chk("wr_addr", 64'(wr_addr), 64'(mon_e.a));
            chk("wr_data", 64'(reg_out[{mon_e.a, 3'b000} +: 8]), 64'(mon_e.d));
         end
      end
   end

   // Pin-level rules checked every cycle: OE tracks busy, OE drops once CS is high, MISO quiet when OE low.
   always @(negedge clk) begin
      if (spi_cs_n === 1'b1) cs_hi_cnt++;
      else cs_hi_cnt = 0;
      if (cs_hi_cnt >= 5) chk("oe_while_cs_high", 64'(spi_miso_oe), 64'd0);
      chk("oe_eq_busy", 64'(spi_miso_oe), 64'(busy));
      if (spi_miso_oe === 1'b0) chk("miso_when_oe_low", 64'(spi_miso), 64'd0);
   end

   task automatic spi_bit(input logic b, input bit cs_up, output logic r);
      spi_mosi = b;
      repeat (4) @(negedge clk);
      r = spi_miso;
      spi_sck = 1'b1;
      if (cs_up) spi_cs_n = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] tx, input bit cs_up, output logic [7:0] rx);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(tx[i], cs_up && (i == 0), b);
         rx[i] = b;
      end
   endtask

   task automatic cs_start();
      spi_cs_n = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_end();
      repeat (4) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // Write command followed by every byte in bq; expected pulses are queued as bytes are driven.
   task automatic do_write(input logic [7:0] cmd, input bit cs_with_last);
      logic [2:0] a;
      logic [7:0] r;
      wexp_t      ne;
      int         n;
      a = cmd[2:0];
      n = bq.size();
      cs_start();
      spi_byte(cmd, 1'b0, r);
      chk("miso_in_cmd", 64'(r), 64'd0);
      for (int k = 0; k < n; k++) begin
         ne.a = a;
         ne.d = (a == 3'd7) ? ID : bq[k];
         wq.push_back(ne);
         if (a != 3'd7) model[a] = bq[k];
         spi_byte(bq[k], cs_with_last && (k == n - 1), r);
         chk("miso_in_write", 64'(r), 64'd0);
         a++;
      end
      bq.delete();
      if (cs_with_last) repeat (12) @(negedge clk);
      else cs_end();
   endtask

   // Read command followed by n dummy bytes; each byte returned is checked against rq.
   task automatic do_read(input logic [7:0] cmd, input int n, input string nm);
      logic [7:0] r;
      cs_start();
      spi_byte(cmd, 1'b0, r);
      chk("miso_in_cmd", 64'(r), 64'd0);
      for (int k = 0; k < n; k++) begin
         spi_byte(8'h00, 1'b0, r);
         if (rq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got %h, no expected value queued", nm, r);
         end else begin
            chk(nm, 64'(r), 64'(rq.pop_front()));
         end
      end
      cs_end();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vt [10];
      logic [7:0] r;
      logic       b;
      logic [2:0] ta;
      logic [7:0] td;

      vt[0] = '{8'h00, 8'hC3, 8'hC3};
      vt[1] = '{8'h06, 8'h96, 8'h96};
      vt[2] = '{8'h86, 8'h00, 8'h96};
      vt[3] = '{8'h80, 8'h00, 8'hC3};
      vt[4] = '{8'h87, 8'h00, 8'hA5};
      vt[5] = '{8'h07, 8'hFF, 8'hA5};
      vt[6] = '{8'h87, 8'h00, 8'hA5};
      vt[7] = '{8'h7D, 8'h81, 8'h81};
      vt[8] = '{8'hFD, 8'h00, 8'h81};
      vt[9] = '{8'h81, 8'h00, 8'h00};

      reset_n  = 1'b0;
      spi_cs_n = 1'b1;
      spi_sck  = 1'b0;
      spi_mosi = 1'b0;
      for (int i = 0; i < 7; i++) model[i] = 8'h00;
      model[7] = ID;
      repeat (3) @(negedge clk);
      chk("rst_reg_out", reg_out, 64'hA500_0000_0000_0000);
      chk("rst_miso", 64'(spi_miso), 64'd0);
      chk("rst_oe", 64'(spi_miso_oe), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_wr_pulse", 64'(wr_pulse), 64'd0);
      chk("rst_wr_addr", 64'(wr_addr), 64'd0);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);

      // Burst write to 2 and 3.
      bq.push_back(8'h11);
      bq.push_back(8'h22);
      do_write(8'h02, 1'b0);
      chk("burst_regs", reg_out, 64'hA500_0000_2211_0000);

      // Burst write 6,7,0 (address wraps, 7 pulses but is not written), then read with wrap.
      bq.push_back(8'h5C);
      bq.push_back(8'h77);
      bq.push_back(8'h3E);
      do_write(8'h06, 1'b0);
      chk("wrap_regs", reg_out, 64'hA55C_0000_2211_003E);
      rq.push_back(8'h5C);
      rq.push_back(8'hA5);
      rq.push_back(8'h3E);
      do_read(8'h86, 3, "rd_wrap");

      // Table of single-byte operations.
      for (int v = 0; v < 10; v++) begin
         ta = vt[v].cmd[2:0];
         if (vt[v].cmd[7]) begin
            rq.push_back(vt[v].exp);
            do_read(vt[v].cmd, 1, "tbl_rd");
         end else begin
            bq.push_back(vt[v].dat);
            do_write(vt[v].cmd, 1'b0);
            chk("tbl_wr_reg", 64'(reg_out[{ta, 3'b000} +: 8]), 64'(vt[v].exp));
         end
      end

      // Partial byte at CS deassert is discarded.
      cs_start();
      spi_byte(8'h01, 1'b0, r);
      for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b0, b);
      cs_end();
      chk("abort_reg1", 64'(reg_out[15:8]), 64'h00);

      // CS deasserts together with the 8th SCK rise: byte still completes.
      bq.push_back(8'h6B);
      do_write(8'h03, 1'b1);
      chk("cs_last_reg3", 64'(reg_out[31:24]), 64'h6B);

      // Reset during the 2nd data bit of a write to reg4.
      cs_start();
      spi_byte(8'h04, 1'b0, r);
      spi_bit(1'b1, 1'b0, b);
      spi_mosi = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("midrst_reg_out", reg_out, 64'hA500_0000_0000_0000);
      chk("midrst_oe", 64'(spi_miso_oe), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_miso", 64'(spi_miso), 64'd0);
      chk("midrst_wr_pulse", 64'(wr_pulse), 64'd0);
      chk("midrst_wr_addr", 64'(wr_addr), 64'd0);
      for (int i = 0; i < 7; i++) model[i] = 8'h00;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
      for (int i = 0; i < 6; i++) spi_bit(1'b1, 1'b0, b);
      spi_byte(8'h5A, 1'b0, r);
      chk("ignored_busy", 64'(busy), 64'd0);
      cs_end();
      chk("midrst_after", reg_out, 64'hA500_0000_0000_0000);
      bq.push_back(8'h99);
      do_write(8'h04, 1'b0);
      chk("post_rst_reg4", 64'(reg_out[39:32]), 64'h99);
      rq.push_back(8'h99);
      do_read(8'h84, 1, "post_rst_rd");

      // Random write/read pairs at clk/8.
      for (int p = 0; p < 64; p++) begin
         ta = 3'($urandom_range(0, 7));
         td = 8'($urandom_range(0, 255));
         bq.push_back(td);
         do_write({5'b00000, ta}, 1'b0);
         rq.push_back(model[ta]);
         do_read({1'b1, 4'b0000, ta}, 1, "rand_rd");
      end

      repeat (10) @(negedge clk);
      chk("wq_drained", 64'(wq.size()), 64'd0);
      chk("rq_drained", 64'(rq.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/spi_slave_regfile.md
SPI_SLAVE_REGFILE -- requirements
Module: spi_slave_regfile

Interface
REQ-001 Parameter ID_VALUE, default 8'hA5, read-only contents of register 7.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops on spi_cs_n, spi_sck and spi_mosi.
REQ-003 clk  input  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 spi_cs_n  input  1  SPI chip select from master, active low.
REQ-006 spi_sck  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0).
REQ-007 spi_mosi  input  1  master-to-slave data, MSB first.
REQ-008 spi_miso  output  1  slave-to-master data, MSB first.
REQ-009 spi_miso_oe  output  1  MISO output enable for the top-level tri-state buffer.
REQ-010 reg_out  output  64  registers 0..7 flattened; reg N occupies bits [8N+7:8N].
REQ-011 wr_pulse  output  1  one-clk pulse per completed register write.
REQ-012 wr_addr  output  3  address of the write flagged by wr_pulse.
REQ-013 busy  output  1  high while a transaction is in progress (synchronized CS asserted).

Function
REQ-014 Each SPI input SHALL pass through SYNC_STAGES flops; SCK rise/fall and CS assert/deassert SHALL be detected from the synchronized values.
REQ-015 The correct-operation range SHALL be f(spi_sck) <= f(clk)/8; behaviour above that limit is undefined.
REQ-016 Transaction format: command byte {rw, 4'b0 reserved, addr[2:0]} (rw=1 read), followed by zero or more data bytes.
REQ-017 FSM states: IDLE, CMD, WRITE, READ.
REQ-018 IDLE -> CMD on CS assert; bit counter cleared.
REQ-019 CMD: sample MOSI on each synchronized SCK rise; after the 8th bit, go to READ if rw=1, otherwise go to WRITE; latch addr.
REQ-020 Reserved command bits SHALL be ignored.
REQ-021 WRITE: after each 8 received bits, reg[addr] SHALL be updated, except that addr 7 SHALL not be updated.
REQ-022 WRITE: after each 8 received bits, wr_pulse=1 for one clk with wr_addr=addr; this SHALL occur for addr 7 as well.
REQ-023 WRITE: after each 8 received bits, addr SHALL increment modulo 8 (7 -> 0).
REQ-024 READ: at command completion, the shifter SHALL be loaded with reg[addr], and its MSB SHALL drive spi_miso before the next SCK rise.
REQ-025 READ: on each SCK fall, the shifter SHALL shift to the next bit.
REQ-026 READ: after 8 bits, addr SHALL increment modulo 8 and the shifter SHALL be reloaded.
REQ-027 Register 7 SHALL always read ID_VALUE.
REQ-028 During CMD and WRITE, spi_miso=0.
REQ-029 spi_miso_oe SHALL equal busy.
REQ-030 CS deassert in any state SHALL return the FSM to IDLE within 1 clk after synchronization.
REQ-031 A partial byte at CS deassert SHALL be discarded; no register write and no wr_pulse SHALL occur.
REQ-032 A CS deassert coinciding with the 8th SCK rise of a byte SHALL complete that byte, write/pulse first, then go to IDLE.
REQ-033 CS re-assert without an intervening clk in IDLE SHALL start a new command byte.
REQ-034 Registers 0..6 SHALL change only via completed SPI write bytes.

Reset
REQ-035 On reset_n=0, asynchronously: FSM=IDLE, registers 0..6=8'h00, counters and shifters 0, spi_miso=0, spi_miso_oe=0, wr_pulse=0, wr_addr=0, busy=0, synchronizer flops set to the idle level (cs_n=1, sck=0, mosi=0).
REQ-036 Reset asserted mid-transaction SHALL abort it with no register write.
REQ-037 After reset release, a transaction already in progress on the bus SHALL be ignored until CS deasserts and re-asserts.

Verification
REQ-038 Write burst: CS low, send 0x02, 0x11, 0x22 -> reg2=0x11, reg3=0x22; wr_pulse twice with wr_addr 2 then 3; other registers remain 0x00.
REQ-039 Read with wrap: preload reg6=0x5C, reg0=0x3E; send 0x86 then 3 dummy bytes -> MISO returns 0x5C, 0xA5, 0x3E.
REQ-040 Read-only register: write 0x07, 0xFF -> wr_pulse with wr_addr=7; a following read of 0x87 returns 0xA5.
REQ-041 Aborted byte: send 0x01, then 5 bits of 0xFF, then CS high -> reg1 unchanged at 0x00; no wr_pulse.
REQ-042 Reset mid-transfer: assert reset_n=0 during the 2nd data bit of a write to reg4 -> all outputs at reset values immediately; reg4=0x00; the next full transaction succeeds.
REQ-043 Rate limit: SCK at clk/8 with random data on 64 write/read pairs -> every readback matches the written value; miso_oe high only while CS is low.
